trng_word_collector: RTL and testbench

//  Parametrised successor to the fixed 32-PDL / 8-counter TRNG core.
//  - Drives per-group delay codes to an external PDL array and XOR-compresses the returned z vector to one raw bit/cycle.
//  - Packs raw bits into WORD_W-bit words and presents them on a valid/ready port.
//  - Runs a repetition-count health test that blocks output on a stuck source.

---
 rtl/trng_word_collector.sv | 142 ++++++++++++++
 tb/tb_trng_word_collector.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/trng_word_collector.sv
// Delay-code driver, XOR compressor, repetition health test and word packer for a PDL TRNG.
// Define TRNG_VN_DEBIAS_EN to insert a Von Neumann corrector ahead of word assembly.
module trng_word_collector #(
    parameter int unsigned NUM_CH    = 32,
    parameter int unsigned NUM_GRP   = 8,
    parameter int unsigned DEL_W     = 3,
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned RPT_LIMIT = 32
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       en,
    input  logic [NUM_CH-1:0]          z,
    output logic [NUM_GRP*DEL_W-1:0]   del,
    input  logic                       hf_clr,
    output logic [WORD_W-1:0]          rnd_word,
    output logic                       rnd_valid,
    input  logic                       rnd_ready,
    output logic                       health_fail
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);
    localparam int unsigned REP_W = $clog2(RPT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
    localparam logic [REP_W-1:0] REP_MAX  = REP_W'(RPT_LIMIT);

    logic [NUM_GRP-1:0][DEL_W-1:0] del_q, del_d;
    logic                          raw_q, bit_vld_q, prev_q, hf_q;
    logic                          prev_d, hf_d;
    logic [REP_W-1:0]              rep_q, rep_d, rep_nxt;
    logic [WORD_W-1:0]             shift_q, shift_d, word_q, word_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          valid_q, valid_d;
    logic                          trip, run, acc, acc_bit, handshake;
`ifdef TRNG_VN_DEBIAS_EN
    logic                          vn_phase_q, vn_phase_d, vn_first_q, vn_first_d;
`endif

    assign del         = del_q;
    assign rnd_word    = word_q;
    assign rnd_valid   = valid_q;
    assign health_fail = hf_q;

    always_comb begin
        for (int g = 0; g < NUM_GRP; g++) begin
            del_d[g] = en ? del_q[g] + DEL_W'(1) : del_q[g];
        end
    end

    always_comb begin
        // Health test runs on every raw bit, independent of assembly state.
        if (raw_q != prev_q)       rep_nxt = REP_W'(1);
        else if (rep_q == REP_MAX) rep_nxt = rep_q;
        else                       rep_nxt = rep_q + REP_W'(1);
        trip   = bit_vld_q && (rep_nxt == REP_MAX) && !hf_clr;
        prev_d = bit_vld_q ? raw_q : prev_q;
        rep_d  = hf_clr ? '0 : (bit_vld_q ? rep_nxt : rep_q);
        hf_d   = hf_clr ? 1'b0 : (hf_q || trip);
        run    = bit_vld_q && !hf_q && !hf_clr && !trip;
    end

`ifdef TRNG_VN_DEBIAS_EN
    always_comb begin
        vn_phase_d = vn_phase_q;
        vn_first_d = vn_first_q;
        acc        = 1'b0;
        acc_bit    = vn_first_q;
        if (hf_clr) begin
            vn_phase_d = 1'b0;
        end else if (run) begin
            vn_phase_d = !vn_phase_q;
            if (!vn_phase_q) vn_first_d = raw_q;
            else             acc        = (vn_first_q != raw_q);
        end
    end
`else
    assign acc     = run;
    assign acc_bit = raw_q;
`endif

    always_comb begin
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        valid_d   = valid_q;
        handshake = valid_q && rnd_ready;
        if (acc && (cnt_q < CNT_FULL)) begin
            shift_d = {shift_q[WORD_W-2:0], acc_bit};
            cnt_d   = cnt_q + CNT_W'(1);
        end
        if (handshake) valid_d = 1'b0;
        // A completed word waits in the shifter until the holding register frees up.
        if ((cnt_d == CNT_FULL) && (!valid_q || handshake) && !hf_q && !trip) begin
            word_d  = shift_d;
            valid_d = 1'b1;
            cnt_d   = '0;
        end
        if (hf_q || trip) valid_d = 1'b0;
        if (hf_clr)       cnt_d   = '0;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int g = 0; g < NUM_GRP; g++) begin
                del_q[g] <= DEL_W'(g);
            end
            raw_q     <= 1'b0;
            bit_vld_q <= 1'b0;
            prev_q    <= 1'b0;
            rep_q     <= '0;
            hf_q      <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            del_q     <= del_d;
            raw_q     <= en ? ^z : raw_q;
            bit_vld_q <= en;
            prev_q    <= prev_d;
            rep_q     <= rep_d;
            hf_q      <= hf_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
        end
    end

`ifdef TRNG_VN_DEBIAS_EN
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            vn_phase_q <= 1'b0;
            vn_first_q <= 1'b0;
        end else begin
            vn_phase_q <= vn_phase_d;
            vn_first_q <= vn_first_d;
        end
    end
`endif

endmodule

// File: tb/tb_trng_word_collector.sv
// Directed bench for trng_word_collector; with TRNG_VN_DEBIAS_EN defined it runs the
// corrector scenario on a 4-bit word instead of the 32-bit data scenarios.
module tb_trng_word_collector;

`ifdef TRNG_VN_DEBIAS_EN
    localparam int unsigned TW = 4;
`else
    localparam int unsigned TW = 32;
`endif

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          en = 1'b0;
    logic [31:0]   z = '0;
    logic [23:0]   del;
    logic          hf_clr = 1'b0;
    logic [TW-1:0] rnd_word;
    logic          rnd_valid;
    logic          rnd_ready = 1'b0;
    logic          health_fail;

    int n_chk  = 0;
    int n_pass = 0;
    int zi     = 0;

    trng_word_collector #(
        .NUM_CH(32), .NUM_GRP(8), .DEL_W(3), .WORD_W(TW), .RPT_LIMIT(32)
    ) dut (
        .clk(clk), .clr(clr), .en(en), .z(z), .del(del), .hf_clr(hf_clr),
        .rnd_word(rnd_word), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .health_fail(health_fail)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [23:0] del_exp(input int k);
        logic [23:0] r;
        for (int g = 0; g < 8; g++) r[3*g +: 3] = 3'((g + k) % 8);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive z with the requested parity, spreading set bits over all channels.
    task automatic bit_step(input logic b);
        en = 1'b1;
        z  = b ? (32'h1 << (zi % 32)) : (32'h3 << (zi % 31));
        zi++;
        step();
    endtask

    task automatic do_reset();
        en = 1'b0; hf_clr = 1'b0; rnd_ready = 1'b0; z = '0;
        #1 clr = 1'b0;
        #2;
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic feed_word(input logic [31:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) bit_step(w[i]);
    endtask

    logic [31:0] w;
    logic [7:0]  vn_seq;

    initial begin
        // Reset state and delay counting
        do_reset();
        check_val("rst_del", 32'(del), 32'(24'o76543210));
        check_val("rst_word", 32'(rnd_word), 32'h0);
        check_val("rst_valid", 32'(rnd_valid), 32'h0);
        check_val("rst_hf", 32'(health_fail), 32'h0);
        for (int i = 0; i < 3; i++) bit_step(1'b0);
        check_val("del_plus3", 32'(del), 32'(del_exp(3)));

`ifdef TRNG_VN_DEBIAS_EN
        do_reset();
        vn_seq = 8'b01101100;
        for (int i = 0; i < 12; i++) bit_step(vn_seq[7 - (i % 8)]);
        check_val("vn_valid_e12", 32'(rnd_valid), 32'h0);
        bit_step(vn_seq[7 - (12 % 8)]);
        check_val("vn_valid_e13", 32'(rnd_valid), 32'h1);
        check_val("vn_word_e13", 32'(rnd_word), 32'h5);
        for (int i = 13; i < 16; i++) bit_step(vn_seq[7 - (i % 8)]);
        en = 1'b0;
        step();
        check_val("vn_word_hold", 32'(rnd_word), 32'h5);
        check_val("vn_valid_hold", 32'(rnd_valid), 32'h1);
`else
        // Alternating word, then back-to-back second word
        do_reset();
        rnd_ready = 1'b1;
        feed_word(32'hAAAA_AAAA, 31, 0);
        check_val("w1_valid_e32", 32'(rnd_valid), 32'h0);
        w = 32'hCCCC_3333;
        bit_step(w[31]);
        check_val("w1_valid_e33", 32'(rnd_valid), 32'h1);
        check_val("w1_word", 32'(rnd_word), 32'hAAAA_AAAA);
        bit_step(w[30]);
        check_val("w1_consumed", 32'(rnd_valid), 32'h0);
        feed_word(w, 29, 0);
        check_val("w2_valid_e64", 32'(rnd_valid), 32'h0);
        rnd_ready = 1'b0;

        // Stall: holding register stable for 100 cycles, next word waits in the shifter
        w = 32'h1234_5678;
        bit_step(w[31]);
        check_val("w2_valid_e65", 32'(rnd_valid), 32'h1);
        check_val("w2_word", 32'(rnd_word), 32'hCCCC_3333);
        feed_word(w, 30, 0);
        for (int i = 0; i < 68; i++) begin
            bit_step(1'(i % 2));
            if (i == 3 || i == 67) begin
                check_val("stall_valid", 32'(rnd_valid), 32'h1);
                check_val("stall_word", 32'(rnd_word), 32'hCCCC_3333);
            end
        end
        rnd_ready = 1'b1;
        bit_step(1'b0);
        check_val("w3_valid", 32'(rnd_valid), 32'h1);
        check_val("w3_word", 32'(rnd_word), 32'h1234_5678);
        bit_step(1'b1);
        check_val("w3_consumed", 32'(rnd_valid), 32'h0);

        // Stuck source trips the health test; hf_clr restarts assembly
        do_reset();
        rnd_ready = 1'b1;
        for (int i = 0; i < 32; i++) bit_step(1'b1);
        check_val("hf_e32", 32'(health_fail), 32'h0);
        bit_step(1'b0);
        check_val("hf_e33", 32'(health_fail), 32'h1);
        check_val("hf_valid_e33", 32'(rnd_valid), 32'h0);
        bit_step(1'b1); bit_step(1'b0); bit_step(1'b1);
        check_val("hf_sticky", 32'(health_fail), 32'h1);
        w = 32'h5555_5555;
        hf_clr = 1'b1;
        bit_step(w[31]);
        hf_clr = 1'b0;
        check_val("hf_cleared", 32'(health_fail), 32'h0);
        feed_word(w, 30, 0);
        check_val("hf_new_valid_early", 32'(rnd_valid), 32'h0);
        bit_step(1'b1);
        check_val("hf_new_valid", 32'(rnd_valid), 32'h1);
        check_val("hf_new_word", 32'(rnd_word), 32'h5555_5555);

        // en dropped mid-word: delays and partial word held
        do_reset();
        w = 32'hF0E1_D2C3;
        feed_word(w, 31, 22);
        check_val("en_del_e10", 32'(del), 32'(del_exp(10)));
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            z = 32'h0000_0001;
            step();
        end
        check_val("en_del_frozen", 32'(del), 32'(del_exp(10)));
        check_val("en_valid_paused", 32'(rnd_valid), 32'h0);
        feed_word(w, 21, 0);
        check_val("en_valid_e52", 32'(rnd_valid), 32'h0);
        bit_step(1'b0);
        check_val("en_valid_e53", 32'(rnd_valid), 32'h1);
        check_val("en_word", 32'(rnd_word), 32'hF0E1_D2C3);
        check_val("en_del_e53", 32'(del), 32'(del_exp(33)));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
